// File: rtl/types_pkg.sv
// types_pkg: shared ALU opcode and FSM state types for acc_unit.
package types_pkg;
    typedef enum logic [2:0] {XOR, ADD, SUB, NEG, MOV, SAV, SWP, NOP} aluop_t;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/acc_unit_if.sv
// acc_unit_if: request handshake plus accumulator status bundle for acc_unit.
interface acc_unit_if
    import types_pkg::*;
#(
    parameter int WIDTH = 11
);
    logic                    req_valid;
    logic                    req_ready;
    aluop_t                  aluop;
    logic signed [WIDTH-1:0] operand;
    logic                    clr;
    logic                    done;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] bak;
    logic                    zero;
    logic                    neg;
    logic                    sat;
    modport master (
        output req_valid, aluop, operand, clr,
        input  req_ready, done, acc, bak, zero, neg, sat
    );
    modport slave (
        input  req_valid, aluop, operand, clr,
        output req_ready, done, acc, bak, zero, neg, sat
    );
endinterface

// File: rtl/sat_clamp.sv
// sat_clamp: clamps a WIDTH+1 bit signed value into [-SAT_MAX, +SAT_MAX].
module sat_clamp #(
    parameter int WIDTH   = 11,
    parameter int SAT_MAX = 999
) (
    input  logic signed [WIDTH:0]   i_val,
    output logic signed [WIDTH-1:0] o_val,
    output logic                    o_sat
);
    localparam logic signed [WIDTH:0] L_MAX = (WIDTH+1)'(SAT_MAX);
    localparam logic signed [WIDTH:0] L_MIN = -L_MAX;
    logic w_hi;
    logic w_lo;
    assign w_hi  = i_val > L_MAX;
    assign w_lo  = i_val < L_MIN;
    assign o_sat = w_hi || w_lo;
    assign o_val = WIDTH'(w_hi ? L_MAX : w_lo ? L_MIN : i_val);
endmodule

// File: rtl/acc_unit.sv
// acc_unit: saturating accumulator with backup register, three-state
// IDLE/EXEC/DONE sequencer, one op per three cycles.
module acc_unit
    import types_pkg::*;
#(
    parameter int WIDTH   = 11,
    parameter int SAT_MAX = 999
) (
    input  logic      CLK,
    input  logic      rst,
    acc_unit_if.slave bus
);
    if (SAT_MAX > 2**(WIDTH-1)-1 || SAT_MAX < 0) begin : g_bad_sat_max
        $error("acc_unit: SAT_MAX does not fit a signed WIDTH-bit value");
    end

    state_t                  r_state;
    state_t                  w_next;
    aluop_t                  r_op;
    logic signed [WIDTH-1:0] r_opnd;
    logic                    r_opnd_sat;
    logic signed [WIDTH-1:0] r_acc;
    logic signed [WIDTH-1:0] r_bak;
    logic                    r_sat;
    logic                    w_xfer;
    logic signed [WIDTH-1:0] w_opnd;
    logic                    w_opnd_sat;
    logic signed [WIDTH:0]   w_acc_x;
    logic signed [WIDTH:0]   w_opnd_x;
    logic signed [WIDTH:0]   w_raw;
    logic signed [WIDTH-1:0] w_res;
    logic                    w_res_sat;
    logic                    w_arith;

    assign bus.req_ready = r_state == IDLE && !bus.clr;
    assign w_xfer        = bus.req_valid && bus.req_ready;
    assign bus.done      = r_state == DONE && !bus.clr;
    assign bus.acc       = r_acc;
    assign bus.bak       = r_bak;
    assign bus.sat       = r_sat;
    assign bus.zero      = r_acc == '0;
    assign bus.neg       = r_acc[WIDTH-1];

    sat_clamp #(.WIDTH(WIDTH), .SAT_MAX(SAT_MAX)) u_opnd_clamp (
        .i_val ({bus.operand[WIDTH-1], bus.operand}),
        .o_val (w_opnd),
        .o_sat (w_opnd_sat)
    );

    // Results are formed one bit wider so ADD/SUB overflow is seen before clamping.
    assign w_acc_x  = {r_acc[WIDTH-1], r_acc};
    assign w_opnd_x = {r_opnd[WIDTH-1], r_opnd};
    assign w_arith  = r_op inside {ADD, SUB, NEG, XOR, MOV};
    assign w_raw    = r_op == ADD ? w_acc_x + w_opnd_x :
                      r_op == SUB ? w_acc_x - w_opnd_x :
                      r_op == NEG ? -w_acc_x :
                      r_op == XOR ? w_acc_x ^ w_opnd_x :
                      r_op == MOV ? w_opnd_x : w_acc_x;

    sat_clamp #(.WIDTH(WIDTH), .SAT_MAX(SAT_MAX)) u_res_clamp (
        .i_val (w_raw),
        .o_val (w_res),
        .o_sat (w_res_sat)
    );

    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE)
            w_next = w_xfer ? EXEC : IDLE;
        else if (r_state == EXEC)
            w_next = DONE;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_op       <= NOP;
            r_opnd     <= '0;
            r_opnd_sat <= 1'b0;
        end else if (w_xfer) begin
            r_op       <= bus.aluop;
            r_opnd     <= w_opnd;
            r_opnd_sat <= w_opnd_sat;
        end
    end

    // NEG ignores the operand, so an operand clamp does not flag it.
    always_ff @(posedge CLK) begin
        if (rst || bus.clr) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_bak   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == EXEC) begin
                r_acc <= w_arith ? w_res : r_op == SWP ? r_bak : r_acc;
                r_bak <= r_op inside {SAV, SWP} ? r_acc : r_bak;
                r_sat <= w_arith && (w_res_sat || (r_opnd_sat && r_op != NEG));
            end
        end
    end
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: scenario tasks for acc_unit with a queue scoreboard checked on every done pulse.
module tb_acc_unit;
    import types_pkg::*;

    typedef struct {
        int   acc;
        int   bak;
        logic sat;
    } exp_t;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   m_acc = 0;
    int   m_bak = 0;
    exp_t sbq[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    acc_unit_if #(.WIDTH(11)) bus ();

    acc_unit #(.WIDTH(11), .SAT_MAX(999)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    function automatic int clampv(int x);
        return x > 999 ? 999 : x < -999 ? -999 : x;
    endfunction

    function automatic void model_push(aluop_t op, int v);
        exp_t e;
        int o;
        int r;
        logic osat;
        logic signed [10:0] x;
        o = clampv(v);
        osat = o != v;
        r = m_acc;
        e.sat = 1'b0;
        case (op)
            ADD: r = m_acc + o;
            SUB: r = m_acc - o;
            NEG: r = -m_acc;
            XOR: begin x = 11'(m_acc) ^ 11'(o); r = x; end
            MOV: r = o;
            default: r = m_acc;
        endcase
        if (op inside {ADD, SUB, NEG, XOR, MOV}) begin
            e.sat = (clampv(r) != r) || (osat && op != NEG);
            m_acc = clampv(r);
        end else if (op == SAV) begin
            m_bak = m_acc;
        end else if (op == SWP) begin
            r = m_acc;
            m_acc = m_bak;
            m_bak = r;
        end
        e.acc = m_acc;
        e.bak = m_bak;
        sbq.push_back(e);
    endfunction

    always @(negedge CLK) begin
        if (!rst && bus.done) begin
            exp_t e;
            done_cnt++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cycle %0d acc=%0d", cyc, bus.acc);
            end else begin
                e = sbq.pop_front();
                if (int'(bus.acc) !== e.acc || int'(bus.bak) !== e.bak || bus.sat !== e.sat) begin
                    errors++;
                    $display("FAIL scoreboard got acc=%0d bak=%0d sat=%0b exp acc=%0d bak=%0d sat=%0b",
                             bus.acc, bus.bak, bus.sat, e.acc, e.bak, e.sat);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.clr = 1'b0;
        bus.aluop = NOP;
        bus.operand = '0;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        m_acc = 0;
        m_bak = 0;
        sbq.delete();
    endtask

    task automatic do_op(input aluop_t op, input int v);
        int n = 0;
        @(negedge CLK);
        while (!bus.req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got %0b exp 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.aluop = op;
        bus.operand = 11'(v);
        model_push(op, v);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL latency_exec done got %0b exp 0", bus.done);
        end
        @(negedge CLK);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL latency_done done got %0b exp 1", bus.done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.acc !== 11'sd0 || bus.bak !== 11'sd0 || bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got acc=%0d bak=%0d sat=%0b exp 0 0 0", bus.acc, bus.bak, bus.sat);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.zero !== 1'b1 || bus.neg !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags got done=%0b zero=%0b neg=%0b ready=%0b exp 0 1 0 1",
                     bus.done, bus.zero, bus.neg, bus.req_ready);
        end
    endtask

    task automatic test_add_sat();
        do_reset();
        do_op(MOV, 500);
        do_op(ADD, 500);
        checks++;
        if (bus.acc !== 11'sd999 || bus.sat !== 1'b1) begin
            errors++;
            $display("FAIL add_sat got acc=%0d sat=%0b exp 999 1", bus.acc, bus.sat);
        end
    endtask

    task automatic test_sub_neg();
        do_reset();
        do_op(SUB, 1);
        checks++;
        if (bus.acc !== -11'sd1 || bus.neg !== 1'b1 || bus.zero !== 1'b0 || bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL sub_neg got acc=%0d neg=%0b zero=%0b sat=%0b exp -1 1 0 0",
                     bus.acc, bus.neg, bus.zero, bus.sat);
        end
        do_op(XOR, -3);
        checks++;
        if (bus.acc !== 11'sd2) begin
            errors++;
            $display("FAIL xor got acc=%0d exp 2", bus.acc);
        end
    endtask

    task automatic test_swap();
        do_op(MOV, 42);
        do_op(SAV, 0);
        do_op(MOV, 7);
        do_op(SWP, 0);
        checks++;
        if (bus.acc !== 11'sd42 || bus.bak !== 11'sd7) begin
            errors++;
            $display("FAIL swap got acc=%0d bak=%0d exp 42 7", bus.acc, bus.bak);
        end
        do_op(NOP, 5);
        checks++;
        if (bus.acc !== 11'sd42 || bus.bak !== 11'sd7 || bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL nop got acc=%0d bak=%0d sat=%0b exp 42 7 0", bus.acc, bus.bak, bus.sat);
        end
    endtask

    task automatic test_clr_abort();
        int d0;
        do_reset();
        do_op(MOV, 3);
        do_op(SAV, 0);
        do_op(MOV, 1023);
        @(negedge CLK);
        d0 = done_cnt;
        bus.req_valid = 1'b1;
        bus.aluop = ADD;
        bus.operand = 11'sd5;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        bus.clr = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready_low got %0b exp 0", bus.req_ready);
        end
        @(negedge CLK);
        bus.clr = 1'b0;
        checks++;
        if (bus.acc !== 11'sd0 || bus.bak !== 11'sd0 || bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL clr_regs got acc=%0d bak=%0d sat=%0b exp 0 0 0", bus.acc, bus.bak, bus.sat);
        end
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_ready_after got %0b exp 1", bus.req_ready);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL clr_no_done got %0d pulses exp %0d", done_cnt, d0);
        end
        m_acc = 0;
        m_bak = 0;
        bus.clr = 1'b1;
        bus.req_valid = 1'b1;
        bus.operand = 11'sd9;
        @(negedge CLK);
        bus.clr = 1'b0;
        bus.req_valid = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (done_cnt !== d0 || bus.acc !== 11'sd0) begin
            errors++;
            $display("FAIL clr_wins got pulses=%0d acc=%0d exp %0d 0", done_cnt, bus.acc, d0);
        end
    endtask

    task automatic test_neg_sat();
        do_reset();
        do_op(MOV, -999);
        do_op(NEG, 0);
        checks++;
        if (bus.acc !== 11'sd999 || bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL neg_min got acc=%0d sat=%0b exp 999 0", bus.acc, bus.sat);
        end
        do_op(MOV, 1023);
        checks++;
        if (bus.acc !== 11'sd999 || bus.sat !== 1'b1) begin
            errors++;
            $display("FAIL mov_clamp got acc=%0d sat=%0b exp 999 1", bus.acc, bus.sat);
        end
    endtask

    task automatic test_back_to_back();
        int t[$];
        int d0;
        int n = 0;
        do_reset();
        d0 = done_cnt;
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.aluop = ADD;
        bus.operand = 11'sd1;
        while (t.size() < 4 && n < 40) begin
            if (bus.req_ready) begin
                t.push_back(cyc);
                model_push(ADD, 1);
            end
            @(negedge CLK);
            n++;
        end
        bus.req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (t.size() != 4) begin
            errors++;
            $display("FAIL b2b_transfers got %0d exp 4", t.size());
        end
        for (int i = 1; i < t.size(); i++) begin
            checks++;
            if (t[i] - t[i-1] != 3) begin
                errors++;
                $display("FAIL b2b_spacing got %0d exp 3", t[i] - t[i-1]);
            end
        end
        checks++;
        if (done_cnt - d0 != 4 || bus.acc !== 11'sd4) begin
            errors++;
            $display("FAIL b2b_result got pulses=%0d acc=%0d exp 4 4", done_cnt - d0, bus.acc);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.clr = 1'b0;
        bus.aluop = NOP;
        bus.operand = '0;
        test_reset();
        test_add_sat();
        test_sub_neg();
        test_swap();
        test_clr_abort();
        test_neg_sat();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
